stream_demux: RTL
=================

Name: stream_demux

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each accepted input beat is routed to one output channel, or copied to all channels, according to the mode:
  - fixed: route by the sel input.
  - round-robin: route by an internal pointer.
  - broadcast: copy to every channel.
- Sits between a single producer, such as a control/test stimulus source, and N buffered consumers.
- Generalises the two-output combinational demux into a flow-controlled, N-way block.

Parameters:
- WIDTH, 8, data bits per beat.
- N, 4, number of output channels (2..16).
- SELW, $clog2(N), derived localparam; width of sel and of the round-robin pointer.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  00 fixed, 01 round-robin, 10 broadcast, 11 reserved.
- sel  input  SELW  target channel in fixed mode; ignored in other modes.
- in_data  input  WIDTH  input beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  N  per-channel beat present.
- out_ready  input  N  per-channel consumer accepts.
- rr_ptr  output  SELW  current round-robin pointer.
- err_drop  output  1  one-cycle pulse when a beat is discarded (sel >= N).

Behaviour:
- Reset: on reset=1 at a clock edge, the following are cleared on that edge regardless of in_valid and out_ready:
  - out_valid = 0, out_data = 0, rr_ptr = 0, err_drop = 0.
  - Any held beat is discarded.
- Channel slot: each channel has a one-entry output register. The slot can load this cycle when (!out_valid[i] || out_ready[i]).
  - Drain: out_ready[i] && out_valid[i] with no new load -> out_valid[i] = 0 next cycle.
- Target set T, evaluated combinationally each cycle:
  - fixed: T = {sel}.
  - round-robin: T = {rr_ptr}.
  - broadcast: T = all channels.
  - mode 11: T is empty and in_ready = 0; the input stalls.
- in_ready: 1 iff every channel in T can load.
  - Exception: fixed mode with sel >= N (possible only when N is not a power of two) -> in_ready = 1.
- Accept: in_valid && in_ready at an edge.
  - For each i in T: out_data[i] <= in_data and out_valid[i] <= 1.
  - Latency is exactly 1 cycle from accept to out_valid.
  - A drain and a load of the same slot on one edge keep out_valid=1 and take the new data; full throughput is 1 beat/cycle per channel.
- Drop: accept in fixed mode with sel >= N -> no slot changes; err_drop = 1 for the following cycle only.
- Round-robin pointer:
  - Advances on each accept in round-robin mode only: rr_ptr <= (rr_ptr == N-1) ? 0 : rr_ptr+1.
  - Holds in all other modes.
  - A mode change does not clear it; only reset does.
- Broadcast is all-or-nothing: no partial delivery. One stalled channel stalls the input.
- in_ready has no combinational dependency on in_valid. It depends combinationally on out_ready, mode, sel and rr_ptr.
- Non-target channels are unaffected by an accept and continue to drain independently.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] holds.
- Reset mid-operation: pending beats are lost; the producer must re-send after reset.

Decomposition:
- Shared package: mode encodings as constants MODE_FIXED=2'b00, MODE_RR=2'b01, MODE_BCAST=2'b10, MODE_RSVD=2'b11.
- Sub-module: stream_slot (WIDTH), one-entry register with load/drain/valid logic, instantiated N times via generate.
- Top level holds target decode, in_ready reduction, rr_ptr and err_drop.

Test Plan:
- Reset, N=4, WIDTH=8: assert reset for 2 cycles with in_valid=1 and in_data=8'hAA -> out_valid=4'b0000, rr_ptr=0, err_drop=0 throughout and one cycle after release.
- Fixed routing: mode=00, sel=2, in_data=8'h5A for one beat, all out_ready=1 -> next cycle out_valid=4'b0100, channel 2 data = 8'h5A; then sel=0, in_data=8'h11 -> out_valid=4'b0001.
- Backpressure: mode=00, sel=1, out_ready[1]=0, send 8'h01 then 8'h02 -> second beat sees in_ready=0, channel 1 holds 8'h01; raise out_ready[1] -> 8'h02 accepted the same edge, appears next cycle.
- Round-robin wrap: mode=01, all ready, 5 back-to-back beats 8'h10..8'h14 -> delivered to channels 0,1,2,3,0 in order; rr_ptr sequence 0,1,2,3,0,1.
- Broadcast stall: mode=10, out_ready=4'b1011 with channel 2 full, in_data=8'hC3 -> in_ready=0, no channel loads; drain channel 2 -> beat lands on all four channels simultaneously, out_valid=4'b1111.
- Drop and reserved, N=3: mode=00, sel=3, in_valid=1 -> in_ready=1, out_valid unchanged, err_drop=1 for exactly one cycle; mode=11 -> in_ready=0 indefinitely.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
// Mode encodings used by the top-level target decode.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'b00,
    MODE_RR    = 2'b01,
    MODE_BCAST = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer, the demux and N consumers.
// The slave side is the demux; the master side drives it.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/stream_slot.sv
// One-entry output register for a single demux channel.
// A load wins over a drain so back-to-back beats keep valid high.
module stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             free
);

  assign free = !valid || ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux: fixed, round-robin or broadcast.
// Target decode, ready reduction, rr pointer and drop flag live here.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  stream_demux_if.slave   bus,
  output logic [SELW-1:0] rr_ptr,
  output logic            err_drop
);

  mode_e        m;
  logic [N-1:0] tgt;
  logic [N-1:0] free;
  logic [N-1:0] load;
  logic         fixed;
  logic         oob;
  logic         accept;

  assign m   = mode_e'(mode);
  assign oob = 32'(sel) >= 32'(N);

  always_comb begin
    tgt   = '0;
    fixed = 1'b0;
    unique case (1'b1)
      (m == MODE_FIXED): begin
        fixed = 1'b1;
        if (!oob) tgt[sel] = 1'b1;
      end
      (m == MODE_RR):    tgt[rr_ptr] = 1'b1;
      (m == MODE_BCAST): tgt = '1;
      default:           tgt = '0;
    endcase
  end

  // out-of-range sel is swallowed so the producer never stalls on it
  assign bus.in_ready = (fixed && oob) ||
                        ((|tgt) && ((tgt & ~free) == '0));
  assign accept = bus.in_valid && bus.in_ready;
  assign load   = accept ? tgt : '0;

  for (genvar i = 0; i < N; i++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clock (clock),
      .reset (reset),
      .load  (load[i]),
      .din   (bus.in_data),
      .ready (bus.out_ready[i]),
      .dout  (bus.out_data[i*WIDTH +: WIDTH]),
      .valid (bus.out_valid[i]),
      .free  (free[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= accept && fixed && oob;
      if (accept && m == MODE_RR)
        rr_ptr <= (rr_ptr == SELW'(N - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

endmodule
